ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 16-word x 8-bit register-file RAM (ram_16_word).
- Accepts independent read/write requests from ports A and B, serialises them onto the RAM's WE/RE/RA/WA/WD pins and captures read data into per-port result registers.
- Sits between the RAM and its two consumers, e.g. the instruction/operand fetch path and the writeback path.
- Sole driver of the RAM control pins; RE is low whenever no read is in flight, so the RAM's shared Q bus is Z.

Parameters:
- ADDR_W, 4, RAM address width; must match the RAM's 16 words.
- DATA_W, 8, RAM data width.

Ports:
- CLK  in  1  single system clock, rising edge.
- RST_N  in  1  reset; asynchronous assert, active-low.
- A_REQ  in  1  port A request; held high until A_ACK is seen.
- A_WR  in  1  port A op: 1 = write, 0 = read; stable while A_REQ is high.
- A_ADDR  in  ADDR_W  port A word address.
- A_WDATA  in  DATA_W  port A write data.
- A_ACK  out  1  one-cycle completion pulse for port A.
- A_RDATA  out  DATA_W  port A read result register.
- B_REQ, B_WR, B_ADDR, B_WDATA, B_ACK, B_RDATA: identical to the A set, for port B.
- RAM_WE  out  1  to RAM WE.
- RAM_RE  out  1  to RAM RE.
- RAM_RA  out  ADDR_W  to RAM RA.
- RAM_WA  out  ADDR_W  to RAM WA.
- RAM_WD  out  DATA_W  to RAM WD.
- RAM_Q  in  DATA_W  from RAM Q.
- BUSY  out  1  high in BUSY and DONE states.

Behaviour:
- Reset (RST_N low, asynchronous): state = IDLE; LAST = B, so A wins the first tie.
- Reset values: RAM_WE = 0, RAM_RE = 0, RAM_RA = 0, RAM_WA = 0, RAM_WD = 0, A_ACK = 0, B_ACK = 0, A_RDATA = 0, B_RDATA = 0, BUSY = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY:
  - When any eligible REQ is high at the clock edge.
  - Winner's WR, ADDR and WDATA are latched into internal regs; GNT (A or B) and LAST are updated to the winner.
  - Arbitration: one requester -> it wins; both -> the requester != LAST wins.
- BUSY (exactly one cycle):
  - RAM_RA = RAM_WA = latched ADDR; RAM_WD = latched WDATA.
  - Write: RAM_WE = 1, RAM_RE = 0; the RAM commits on the BUSY-ending edge.
  - Read: RAM_RE = 1, RAM_WE = 0; RAM_Q is sampled on the BUSY-ending edge into GNT's RDATA register.
  - Always goes to DONE.
- DONE (one cycle):
  - GNT's ACK = 1; RAM_WE = 0, RAM_RE = 0.
  - GNT's REQ is ignored this cycle (the requester drops it after seeing ACK).
  - Other port's REQ high -> back-to-back to BUSY with that port granted; otherwise -> IDLE.
- Latency:
  - From IDLE: REQ sampled at edge N, BUSY during cycle N+1, ACK during cycle N+2.
  - Back-to-back throughput: one access per 2 cycles.
- A REQ still high in IDLE is a new request; a requester holding REQ gets repeated accesses.
- RDATA registers change only on that port's reads. Writes and the other port's accesses leave them unchanged.
- RAM_RA, RAM_WA and RAM_WD hold their last values in IDLE and DONE; only WE and RE are qualified.
- Reset mid-transaction: RAM_WE drops immediately (asynchronous). The in-flight write is not committed, and no ACK is issued.
- Addresses wrap naturally within ADDR_W; there is no bounds checking.
- WR, ADDR and WDATA changes while REQ is high and before ACK are ignored after latching.

Decomposition:
- Shared package holds:
  - State encoding: ST_IDLE = 2'b00, ST_BUSY = 2'b01, ST_DONE = 2'b10.
  - Port IDs: PORT_A = 1'b0, PORT_B = 1'b1.
  - Default ADDR_W / DATA_W constants shared with the RAM.
- Sub-module rr_arbiter_2:
  - Combinational winner select from two requests, a mask and LAST.
  - LAST flop updated on grant.
  - Reused by later shared-resource blocks.

Test Plan:
- Reset then idle 5 cycles -> RAM_WE = 0, RAM_RE = 0, all ACKs and RDATAs 0, BUSY = 0.
- A write: addr 3, data 0x5A, REQ high at edge 0 -> RAM_WE = 1, RAM_WA = 3, RAM_WD = 0x5A in cycle 1; A_ACK = 1 in cycle 2 only; then B read addr 3 -> B_RDATA = 0x5A with B_ACK, A_RDATA still 0.
- Simultaneous requests after reset: A writes addr 1 = 0x11, B reads addr 1 -> A served first (ACK cycle 2), B granted from DONE with no IDLE (BUSY cycle 3, ACK cycle 4), B_RDATA = 0x11.
- Both held continuously for 8 cycles -> grants alternate A, B, A, B, exactly one ACK every 2 cycles; RAM_WE and RAM_RE never both 1.
- Write addr 7 = 0x22, then write addr 7 = 0xFF with RST_N pulsed low mid-BUSY -> RAM_WE falls immediately, no ACK; a later read of addr 7 returns 0x22.
- Read of addr 15 followed by a write to addr 0 -> wrap addresses correct, RDATA holds 15's value through the write.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter and its helpers.
//   - state_e : sequencer states (idle / RAM access / completion)
//   - port_e  : requester identifiers
//   - RAM_ADDR_W / RAM_DATA_W : geometry of the 16 x 8 register-file RAM
package ram_port_arbiter_pkg;

    localparam int unsigned RAM_ADDR_W = 4;
    localparam int unsigned RAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_A) ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for one RAM client.
//   req   : request, held until ack is seen
//   wr    : 1 = write, 0 = read
//   addr  : word address
//   wdata : write data
//   ack   : one-cycle completion pulse
//   rdata : last read result for this client
// master = requester, slave = arbiter.
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
);

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output wr,
        output addr,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  addr,
        input  wdata,
        output ack,
        output rdata
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : raw requests, bit 0 = PORT_A, bit 1 = PORT_B
//   mask       : requests to ignore this cycle
//   update     : a grant is being taken; remember the winner
//   valid      : at least one unmasked request
//   winner     : selected port (only meaningful when valid)
// After reset the last winner is PORT_B, so PORT_A wins the first tie.
module rr_arbiter_2
    import ram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       update,
    output logic       valid,
    output port_e      winner
);

    logic [1:0] elig;
    port_e      last_q;

    assign elig  = req & ~mask;
    assign valid = |elig;

    always_comb begin
        winner = PORT_A;
        case (elig)
            2'b01:   winner = PORT_A;
            2'b10:   winner = PORT_B;
            2'b11:   winner = other_port(last_q);
            default: winner = PORT_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_B;
        end else if (update && valid) begin
            last_q <= winner;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter / sequencer between two clients and a 16 x 8 register-file RAM.
//   clk, rst_n : clock, asynchronous active-low reset
//   port_a     : client A request bundle (slave side)
//   port_b     : client B request bundle (slave side)
//   ram_we     : RAM write enable (high only in the access cycle of a write)
//   ram_re     : RAM read enable (high only in the access cycle of a read)
//   ram_ra     : RAM read address
//   ram_wa     : RAM write address
//   ram_wd     : RAM write data
//   ram_q      : RAM read data (only valid while ram_re is high)
//   busy       : high while an access or its completion cycle is in progress
// Each access takes one RAM cycle followed by one ack cycle; in the ack cycle the
// other client may be granted directly, giving one access per two cycles.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave port_a,
    ram_port_arbiter_if.slave port_b,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_ra,
    output logic [ADDR_W-1:0] ram_wa,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    state_e            state_q;
    port_e             gnt_q;
    logic              wr_q;

    logic [1:0]        arb_mask;
    logic              arb_update;
    logic              arb_valid;
    port_e             arb_winner;

    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // The granted client still holds req during its ack cycle; mask it so the
    // other client gets the back-to-back slot and a stale request is not re-served.
    always_comb begin
        arb_mask = 2'b11;
        case (state_q)
            ST_IDLE: arb_mask = 2'b00;
            ST_DONE: arb_mask = (gnt_q == PORT_A) ? 2'b01 : 2'b10;
            default: arb_mask = 2'b11;
        endcase
    end

    assign arb_update = (arb_mask != 2'b11);

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({port_b.req, port_a.req}),
        .mask   (arb_mask),
        .update (arb_update),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_comb begin
        if (arb_winner == PORT_B) begin
            sel_wr    = port_b.wr;
            sel_addr  = port_b.addr;
            sel_wdata = port_b.wdata;
        end else begin
            sel_wr    = port_a.wr;
            sel_addr  = port_a.addr;
            sel_wdata = port_a.wdata;
        end
    end

    // ram_ra/ram_wa/ram_wd double as the latched request and hold between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= PORT_A;
            wr_q         <= 1'b0;
            ram_we       <= 1'b0;
            ram_re       <= 1'b0;
            ram_ra       <= '0;
            ram_wa       <= '0;
            ram_wd       <= '0;
            port_a.ack   <= 1'b0;
            port_b.ack   <= 1'b0;
            port_a.rdata <= '0;
            port_b.rdata <= '0;
        end else begin
            port_a.ack <= 1'b0;
            port_b.ack <= 1'b0;
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arb_valid) begin
                        state_q <= ST_BUSY;
                        gnt_q   <= arb_winner;
                        wr_q    <= sel_wr;
                        ram_ra  <= sel_addr;
                        ram_wa  <= sel_addr;
                        ram_wd  <= sel_wdata;
                        ram_we  <= sel_wr;
                        ram_re  <= ~sel_wr;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    state_q <= ST_DONE;
                    if (gnt_q == PORT_A) begin
                        port_a.ack <= 1'b1;
                        if (!wr_q) begin
                            port_a.rdata <= ram_q;
                        end
                    end else begin
                        port_b.ack <= 1'b1;
                        if (!wr_q) begin
                            port_b.rdata <= ram_q;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ram_we, ram_re, busy;
    logic [3:0] ram_ra, ram_wa;
    logic [7:0] ram_wd;
    logic [7:0] ram_q;
    logic       ram_clr = 1'b1;

    int total = 0;
    int bad = 0;

    ram_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) pa ();
    ram_port_arbiter_if #(.ADDR_W(4), .DATA_W(8)) pb ();

    ram_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .port_a (pa),
        .port_b (pb),
        .ram_we (ram_we),
        .ram_re (ram_re),
        .ram_ra (ram_ra),
        .ram_wa (ram_wa),
        .ram_wd (ram_wd),
        .ram_q  (ram_q),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Behavioural register-file RAM
    logic [7:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'h00;
        end else if (ram_we) begin
            ram_mem[ram_wa] <= ram_wd;
        end
    end
    assign ram_q = ram_re ? ram_mem[ram_ra] : 8'hzz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An access granted at edge g occupies the RAM during the following cycle,
    // completes (data stored / read result captured) at edge g+1 and is
    // acknowledged during the cycle after that. A new grant is possible at any
    // edge where no access is occupying the RAM; the client being acknowledged
    // is not eligible at that edge.
    typedef struct {
        bit         v;
        bit         p;
        bit         wr;
        logic [3:0] a;
        logic [7:0] d;
    } acc_t;

    acc_t       g1, g2;
    bit         m_last;
    logic [7:0] m_mem [16];
    logic [7:0] m_rdata [2];
    logic       exp_we, exp_re, exp_ack_a, exp_ack_b, exp_busy;
    logic [3:0] exp_ra, exp_wa;
    logic [7:0] exp_wd;

    task automatic set_outputs();
        exp_we    = g1.v && g1.wr;
        exp_re    = g1.v && !g1.wr;
        exp_ack_a = g2.v && (g2.p == 1'b0);
        exp_ack_b = g2.v && (g2.p == 1'b1);
        exp_busy  = g1.v || g2.v;
    endtask

    task automatic model_reset();
        g1 = '{default: 0};
        g2 = '{default: 0};
        m_last = 1'b1;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
        exp_ra = 4'h0;
        exp_wa = 4'h0;
        exp_wd = 8'h00;
        set_outputs();
    endtask

    task automatic model_step();
        acc_t g0;
        bit   ea, eb, win;
        g0 = '{default: 0};
        if (g1.v) begin
            if (g1.wr) m_mem[g1.a] = g1.d;
            else       m_rdata[g1.p] = m_mem[g1.a];
        end
        if (!g1.v) begin
            ea = pa.req && !(g2.v && g2.p == 1'b0);
            eb = pb.req && !(g2.v && g2.p == 1'b1);
            if (ea || eb) begin
                win = (ea && eb) ? !m_last : eb;
                g0.v  = 1'b1;
                g0.p  = win;
                g0.wr = win ? pb.wr : pa.wr;
                g0.a  = win ? pb.addr : pa.addr;
                g0.d  = win ? pb.wdata : pa.wdata;
                m_last = win;
                exp_ra = g0.a;
                exp_wa = g0.a;
                exp_wd = g0.d;
            end
        end
        g2 = g1;
        g1 = g0;
        set_outputs();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cmp_we", ram_we, exp_we);
                check("cmp_re", ram_re, exp_re);
                check("cmp_busy", busy, exp_busy);
                check("cmp_ack_a", pa.ack, exp_ack_a);
                check("cmp_ack_b", pb.ack, exp_ack_b);
                check("cmp_rdata_a", pa.rdata, m_rdata[0]);
                check("cmp_rdata_b", pb.rdata, m_rdata[1]);
                check("cmp_ra", ram_ra, exp_ra);
                check("cmp_wa", ram_wa, exp_wa);
                check("cmp_wd", ram_wd, exp_wd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        pa.req = 1'b0;
        pb.req = 1'b0;
    endtask

    task automatic issue(input bit p, input bit wr, input logic [3:0] a, input logic [7:0] d);
        if (p) begin
            pb.wr = wr; pb.addr = a; pb.wdata = d; pb.req = 1'b1;
        end else begin
            pa.wr = wr; pa.addr = a; pa.wdata = d; pa.req = 1'b1;
        end
    endtask

    // Waits for the port's ack, then drops its request.
    task automatic wait_ack(input bit p, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ((p ? pb.ack : pa.ack) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: got no ack expected ack within 10 cycles", name);
        end
        if (p) pb.req = 1'b0;
        else   pa.req = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drop_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic agent_step(input logic req, input logic ack, input logic wr,
                              input logic [3:0] a, input logic [7:0] d,
                              output logic nreq, output logic nwr,
                              output logic [3:0] na, output logic [7:0] nd);
        nreq = req; nwr = wr; na = a; nd = d;
        if (req && ack) begin
            if ($urandom_range(1, 0) == 0) begin
                nreq = 1'b0;
            end else begin
                nwr = 1'($urandom); na = 4'($urandom); nd = 8'($urandom);
            end
        end else if (!req) begin
            if ($urandom_range(2, 0) == 0) begin
                nreq = 1'b1;
                nwr = 1'($urandom); na = 4'($urandom); nd = 8'($urandom);
            end
        end else if ($urandom_range(3, 0) == 0) begin
            na = 4'($urandom); nd = 8'($urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic       r, w;
        logic [3:0] a;
        logic [7:0] d;
        pa.req = 0; pa.wr = 0; pa.addr = 0; pa.wdata = 0;
        pb.req = 0; pb.wr = 0; pb.addr = 0; pb.wdata = 0;
        repeat (3) @(posedge clk);
        #1 ram_clr = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Idle after reset
        repeat (5) tick();
        @(negedge clk);
        check("idle_we", ram_we, 0);
        check("idle_re", ram_re, 0);
        check("idle_busy", busy, 0);
        check("idle_ack_a", pa.ack, 0);
        check("idle_rdata_b", pb.rdata, 0);
        tick();

        // A writes 3 = 0x5A, then B reads it back
        issue(0, 1, 4'd3, 8'h5A);
        @(posedge clk);
        @(negedge clk);
        check("wr_we", ram_we, 1);
        check("wr_wa", ram_wa, 3);
        check("wr_wd", ram_wd, 8'h5A);
        check("wr_no_early_ack", pa.ack, 0);
        tick();
        pa.req = 1'b0;
        @(negedge clk);
        check("wr_ack", pa.ack, 1);
        tick();
        issue(1, 0, 4'd3, 8'h00);
        @(negedge clk);
        check("wr_ack_once", pa.ack, 0);
        wait_ack(1, "rd_b_ack");
        check("rd_b_data", pb.rdata, 8'h5A);
        check("rd_a_untouched", pa.rdata, 8'h00);

        // Simultaneous: A write 1 = 0x11, B read 1; B served back-to-back
        reset_dut();
        issue(0, 1, 4'd1, 8'h11);
        issue(1, 0, 4'd1, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("sim_a_first", ram_we, 1);
        check("sim_a_addr", ram_wa, 1);
        tick();
        check("sim_a_ack", pa.ack, 1);
        pa.req = 1'b0;
        @(negedge clk);
        check("sim_busy_done", busy, 1);
        @(negedge clk);
        check("sim_b2b_re", ram_re, 1);
        check("sim_b2b_ra", ram_ra, 1);
        tick();
        check("sim_b_ack", pb.ack, 1);
        check("sim_b_data", pb.rdata, 8'h11);
        pb.req = 1'b0;

        // Both held: grants alternate A, B, A, B
        reset_dut();
        issue(0, 0, 4'd1, 8'h00);
        issue(1, 0, 4'd3, 8'h00);
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("rr_ack_a_c%0d", c), pa.ack, (c == 2 || c == 6));
            check($sformatf("rr_ack_b_c%0d", c), pb.ack, (c == 4 || c == 8));
        end
        drop_all();
        tick();

        // Write 7 = 0x22, then a write of 0xFF killed by reset mid-access
        issue(0, 1, 4'd7, 8'h22);
        wait_ack(0, "w7_ack");
        tick();
        tick();
        issue(0, 1, 4'd7, 8'hFF);
        @(posedge clk);
        @(negedge clk);
        check("rst_we_before", ram_we, 1);
        #2;
        rst_n = 1'b0;
        pa.req = 1'b0;
        #1;
        check("rst_we_drop", ram_we, 0);
        check("rst_busy_drop", busy, 0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_ack", pa.ack, 0);
        end
        tick();
        issue(1, 0, 4'd7, 8'h00);
        wait_ack(1, "r7_ack");
        check("r7_data", pb.rdata, 8'h22);

        // Top address, then write to 0; A's result must hold through the write
        tick();
        issue(0, 1, 4'd15, 8'hC3);
        wait_ack(0, "w15_ack");
        issue(0, 0, 4'd15, 8'h00);
        wait_ack(0, "r15_ack");
        check("r15_data", pa.rdata, 8'hC3);
        issue(0, 1, 4'd0, 8'h3C);
        wait_ack(0, "w0_ack");
        check("r15_hold", pa.rdata, 8'hC3);
        issue(1, 0, 4'd0, 8'h00);
        wait_ack(1, "r0_ack");
        check("r0_data", pb.rdata, 8'h3C);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            agent_step(pa.req, pa.ack, pa.wr, pa.addr, pa.wdata, r, w, a, d);
            pa.req = r; pa.wr = w; pa.addr = a; pa.wdata = d;
            agent_step(pb.req, pb.ack, pb.wr, pb.addr, pb.wdata, r, w, a, d);
            pb.req = r; pb.wr = w; pb.addr = a; pb.wdata = d;
        end
        drop_all();
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
